specialist_kbd_matrix: RTL and testbench

- Keyboard front end that feeds the parallel-interface (PPI) port inputs.
- Converts MiSTer-style PS/2 key events into a 6-row × 12-column key matrix plus a dedicated shift line.
- Resolves matrix scans: the PPI drives columns through port A and port C[3:0]; this block returns row states on port B.
- Produces the PPI ipa/ipb/ipc input buses directly from the PPI's opa/opb/opc output buses.

---
 rtl/specialist_kbd_pkg.sv | 27 ++
 rtl/specialist_kbd_map.sv | 82 ++++++++
 rtl/specialist_kbd_matrix.sv | 93 +++++++++
 tb/tb_specialist_kbd_matrix.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/specialist_kbd_pkg.sv
// Shared types and constants for the keyboard matrix front end.
// Matrix geometry, decoded key position bundle and shift scancodes.
package specialist_kbd_pkg;

    localparam int NROWS = 6;
    localparam int NCOLS = 12;

    localparam logic [7:0] SC_SHIFT_L = 8'h12;
    localparam logic [7:0] SC_SHIFT_R = 8'h59;

    typedef struct packed {
        logic       valid;
        logic       is_shift;
        logic [2:0] row;
        logic [3:0] col;
    } key_pos_t;

    function automatic key_pos_t kp(input logic [2:0] r, input logic [3:0] c);
        key_pos_t p;
        p.valid    = 1'b1;
        p.is_shift = 1'b0;
        p.row      = r;
        p.col      = c;
        return p;
    endfunction

endpackage

// File: rtl/specialist_kbd_map.sv
// Scancode to matrix position lookup (pure combinational).
// Shift keys report is_shift with col[0] selecting left(0)/right(1).
module specialist_kbd_map
    import specialist_kbd_pkg::*;
(
    input  logic     ext,
    input  logic [7:0] code,
    output key_pos_t pos
);

    // Case table over {E0 flag, scancode}
    always_comb begin
        pos = '0;
        case ({ext, code})
            {1'b0, SC_SHIFT_L}: pos = '{1'b1, 1'b1, 3'd0, 4'd0};
            {1'b0, SC_SHIFT_R}: pos = '{1'b1, 1'b1, 3'd0, 4'd1};
            9'h016: pos = kp(3'd0, 4'd0);
            9'h01E: pos = kp(3'd0, 4'd1);
            9'h026: pos = kp(3'd0, 4'd2);
            9'h025: pos = kp(3'd0, 4'd3);
            9'h02E: pos = kp(3'd0, 4'd4);
            9'h036: pos = kp(3'd0, 4'd5);
            9'h03D: pos = kp(3'd0, 4'd6);
            9'h03E: pos = kp(3'd0, 4'd7);
            9'h046: pos = kp(3'd0, 4'd8);
            9'h045: pos = kp(3'd0, 4'd9);
            9'h04E: pos = kp(3'd0, 4'd10);
            9'h055: pos = kp(3'd0, 4'd11);
            9'h015: pos = kp(3'd1, 4'd0);
            9'h01D: pos = kp(3'd1, 4'd1);
            9'h024: pos = kp(3'd1, 4'd2);
            9'h02D: pos = kp(3'd1, 4'd3);
            9'h02C: pos = kp(3'd1, 4'd4);
            9'h035: pos = kp(3'd1, 4'd5);
            9'h03C: pos = kp(3'd1, 4'd6);
            9'h043: pos = kp(3'd1, 4'd7);
            9'h044: pos = kp(3'd1, 4'd8);
            9'h04D: pos = kp(3'd1, 4'd9);
            9'h054: pos = kp(3'd1, 4'd10);
            9'h05B: pos = kp(3'd1, 4'd11);
            9'h058: pos = kp(3'd2, 4'd0);
            9'h00D: pos = kp(3'd2, 4'd1);
            9'h076: pos = kp(3'd2, 4'd2);
            9'h01C: pos = kp(3'd2, 4'd3);
            9'h01B: pos = kp(3'd2, 4'd4);
            9'h023: pos = kp(3'd2, 4'd5);
            9'h02B: pos = kp(3'd2, 4'd6);
            9'h034: pos = kp(3'd2, 4'd7);
            9'h033: pos = kp(3'd2, 4'd8);
            9'h03B: pos = kp(3'd2, 4'd9);
            9'h042: pos = kp(3'd2, 4'd10);
            9'h04B: pos = kp(3'd2, 4'd11);
            9'h01A: pos = kp(3'd3, 4'd0);
            9'h022: pos = kp(3'd3, 4'd1);
            9'h021: pos = kp(3'd3, 4'd2);
            9'h02A: pos = kp(3'd3, 4'd3);
            9'h032: pos = kp(3'd3, 4'd4);
            9'h031: pos = kp(3'd3, 4'd5);
            9'h03A: pos = kp(3'd3, 4'd6);
            9'h041: pos = kp(3'd3, 4'd7);
            9'h049: pos = kp(3'd3, 4'd8);
            9'h04A: pos = kp(3'd3, 4'd9);
            9'h04C: pos = kp(3'd3, 4'd10);
            9'h052: pos = kp(3'd3, 4'd11);
            9'h005: pos = kp(3'd4, 4'd0);
            9'h006: pos = kp(3'd4, 4'd1);
            9'h004: pos = kp(3'd4, 4'd2);
            9'h00C: pos = kp(3'd4, 4'd3);
            9'h029: pos = kp(3'd4, 4'd4);
            9'h066: pos = kp(3'd4, 4'd5);
            9'h05A: pos = kp(3'd4, 4'd11);
            9'h15A: pos = kp(3'd4, 4'd11);
            9'h16B: pos = kp(3'd5, 4'd0);
            9'h174: pos = kp(3'd5, 4'd1);
            9'h175: pos = kp(3'd5, 4'd2);
            9'h172: pos = kp(3'd5, 4'd3);
            9'h16C: pos = kp(3'd5, 4'd4);
            default: pos = '0;
        endcase
    end

endmodule

// File: rtl/specialist_kbd_matrix.sv
// PS/2 key events to 6x12 key matrix, scanned through PPI ports.
// Optional row-driven scan onto ipa/ipc: define KBD_REVERSE_SCAN_EN.
module specialist_kbd_matrix
    import specialist_kbd_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  opa,
    input  logic [7:0]  opb,
    input  logic [7:0]  opc,
    input  logic        tape_in,
    output logic [7:0]  ipa,
    output logic [7:0]  ipb,
    output logic [7:0]  ipc,
    output logic        any_key
);

    logic [NROWS-1:0][NCOLS-1:0] km;
    logic                        shift_l;
    logic                        shift_r;
    logic                        tog_q;
    logic                        ev;
    key_pos_t                    pos;
    logic [NCOLS-1:0]            col_drv;
    logic [NROWS-1:0]            row_hit;
    logic                        unused_ok;

    assign ev = ps2_key[10] != tog_q;

    specialist_kbd_map u_map (
        .ext  (ps2_key[8]),
        .code (ps2_key[7:0]),
        .pos  (pos)
    );

    // Key state update, one event per toggle of ps2_key[10]
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            km      <= '0;
            shift_l <= 1'b0;
            shift_r <= 1'b0;
            tog_q   <= ps2_key[10];
        end else if (ev) begin
            tog_q <= ps2_key[10];
            if (pos.valid && pos.is_shift) begin
                if (pos.col[0]) shift_r <= ps2_key[9];
                else            shift_l <= ps2_key[9];
            end else if (pos.valid) begin
                km[pos.row][pos.col] <= ps2_key[9];
            end
        end
    end

    assign col_drv = ~{opc[3:0], opa};

    // Forward scan: a row reads low when a held key sits on a driven column
    always_comb begin
        row_hit = '0;
        for (int r = 0; r < NROWS; r++) begin
            row_hit[r] = |(km[r] & col_drv);
        end
    end

    assign ipb     = {~row_hit, ~(shift_l | shift_r), tape_in};
    assign any_key = (|km) | shift_l | shift_r;

`ifdef KBD_REVERSE_SCAN_EN
    logic [NROWS-1:0] row_drv;
    logic [NCOLS-1:0] col_hit;

    assign row_drv = ~opb[7:2];

    // Reverse scan: a column reads low when a held key sits on a driven row
    always_comb begin
        col_hit = '0;
        for (int c = 0; c < NCOLS; c++) begin
            for (int r = 0; r < NROWS; r++) begin
                col_hit[c] = col_hit[c] | (km[r][c] & row_drv[r]);
            end
        end
    end

    assign ipa = ~col_hit[7:0];
    assign ipc = {4'hF, ~col_hit[11:8]};
`else
    assign ipa = 8'hFF;
    assign ipc = 8'hFF;
`endif

    assign unused_ok = &{1'b0, opb, opc[7:4]};

endmodule

// File: tb/tb_specialist_kbd_matrix.sv
// Directed self-checking bench for specialist_kbd_matrix.
// Expected values are hand-derived from the matrix map and scan rules.
module tb_specialist_kbd_matrix;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [7:0]  opa, opb, opc;
    logic        tape_in;
    logic [7:0]  ipa, ipb, ipc;
    logic        any_key;

    int checks = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    specialist_kbd_matrix dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ps2_key (ps2_key),
        .opa     (opa),
        .opb     (opb),
        .opc     (opc),
        .tape_in (tape_in),
        .ipa     (ipa),
        .ipb     (ipb),
        .ipc     (ipc),
        .any_key (any_key)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic key(input logic e0, input logic [7:0] code, input logic prs);
        ps2_key = {~ps2_key[10], prs, e0, code};
        tick(1);
    endtask

    localparam logic [7:0] REV_IPA = 8'hDF;
    localparam logic [7:0] REV_IPC = 8'hFE;

    initial begin
        logic [7:0] exp_ipa;
        logic [7:0] exp_ipc;
`ifdef KBD_REVERSE_SCAN_EN
        exp_ipa = REV_IPA;
        exp_ipc = REV_IPC;
`else
        exp_ipa = 8'hFF;
        exp_ipc = 8'hFF;
`endif
        reset = 1'b1;
        ps2_key = '0;
        opa = 8'hFF;
        opb = 8'hFF;
        opc = 8'hFF;
        tape_in = 1'b1;
        tick(3);
        chk("rst_ipa", ipa, 8'hFF);
        chk("rst_ipb", ipb, 8'hFF);
        chk("rst_ipc", ipc, 8'hFF);
        chk("rst_any", {7'd0, any_key}, 8'h00);
        reset = 1'b0;
        tick(2);
        chk("idle_ipb", ipb, 8'hFF);

        // 'A' at r2,c3 scanned via column 3
        opa = 8'hF7;
        key(1'b0, 8'h1C, 1'b1);
        chk("a_press_ipb", ipb, 8'hEF);
        chk("a_press_any", {7'd0, any_key}, 8'h01);
        chk("a_press_ipa", ipa, 8'hFF);
        key(1'b0, 8'h1C, 1'b0);
        chk("a_rel_ipb", ipb, 8'hFF);
        chk("a_rel_any", {7'd0, any_key}, 8'h00);

        // Held key on an undriven column, then a col-8 key
        key(1'b0, 8'h1C, 1'b1);
        opa = 8'hFF;
        opc = 8'hFE;
        tick(1);
        chk("undriven_ipb", ipb, 8'hFF);
        key(1'b0, 8'h1C, 1'b0);
        key(1'b0, 8'h46, 1'b1);
        chk("col8_ipb", ipb, 8'hFB);
        key(1'b0, 8'h46, 1'b0);
        chk("col8_rel_ipb", ipb, 8'hFF);

        // Both shifts tracked separately
        key(1'b0, 8'h12, 1'b1);
        key(1'b0, 8'h59, 1'b1);
        chk("shift_both", ipb, 8'hFD);
        key(1'b0, 8'h12, 1'b0);
        chk("shift_r_only", ipb, 8'hFD);
        chk("shift_any", {7'd0, any_key}, 8'h01);
        key(1'b0, 8'h59, 1'b0);
        chk("shift_none", ipb, 8'hFF);
        chk("shift_none_any", {7'd0, any_key}, 8'h00);

        // Unmapped code with all columns driven
        opa = 8'h00;
        opc = 8'hF0;
        key(1'b0, 8'h00, 1'b1);
        chk("unmapped_ipb", ipb, 8'hFF);
        chk("unmapped_any", {7'd0, any_key}, 8'h00);

        // Steady press held 100 clocks, then one release clears it
        key(1'b0, 8'h1C, 1'b1);
        tick(100);
        chk("hold_ipb", ipb, 8'hEF);
        key(1'b0, 8'h1C, 1'b0);
        chk("hold_rel_ipb", ipb, 8'hFF);
        key(1'b0, 8'h1C, 1'b0);
        chk("rel_unheld", ipb, 8'hFF);

        // Enter and keypad enter share r4,c11: last event wins
        key(1'b0, 8'h5A, 1'b1);
        chk("enter_ipb", ipb, 8'hBF);
        key(1'b1, 8'h5A, 1'b0);
        chk("kpenter_rel", ipb, 8'hFF);

        tape_in = 1'b0;
        key(1'b1, 8'h75, 1'b1);
        chk("up_tape0", ipb, 8'h7E);
        tape_in = 1'b1;

        // Reset with a pending press event
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1B};
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        chk("rstp_ipb", ipb, 8'hFF);
        chk("rstp_any", {7'd0, any_key}, 8'h00);

        // Row-driven scan
        opa = 8'hFF;
        opc = 8'hFF;
        opb = 8'hFB;
        key(1'b0, 8'h36, 1'b1);
        chk("rev_ipa", ipa, exp_ipa);
        key(1'b0, 8'h46, 1'b1);
        chk("rev_ipc", ipc, exp_ipc);
        chk("rev_ipb", ipb, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
